// File: rtl/prefetch_pkg.sv
// Shared types and constants for the prefetch DDR read-address path.
package prefetch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    GAP   = 2'd2
  } throttle_state_e;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_WATCHDOG  = 1;
  localparam int ERR_BITS      = 2;

  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_MIN_GAP         = 0;
  localparam int DEF_WATCHDOG_CNT    = 0;

endpackage

// File: rtl/prefetch_watchdog.sv
// Saturating stall counter; timeout pulses while the next count equals a non-zero threshold.
module prefetch_watchdog
  import prefetch_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] threshold_i,
  output logic             timeout_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != {WIDTH{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare the next value so the flag lands on the same edge the count reaches the threshold.
  assign timeout_o = (threshold_i != '0) && (cnt_d == threshold_i);

endmodule

// File: rtl/prefetch_ar_throttle.sv
// AR regulator: caps DRAM read bursts in flight, forces an idle gap after each issue,
// retires bursts from snooped R-last beats and flags stalls through a watchdog.
module prefetch_ar_throttle
  import prefetch_pkg::*;
#(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int LOG_QUEUE_SIZE  = 3,
  parameter int GAP_WIDTH       = 6,
  parameter int WATCHDOG_SIZE   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       s_ar_valid,
  output logic                       s_ar_ready,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       r_valid,
  input  logic                       r_ready,
  input  logic                       r_last,
  input  logic [LOG_QUEUE_SIZE:0]    crs_maxOutstanding,
  input  logic [GAP_WIDTH-1:0]       crs_minGap,
  input  logic [WATCHDOG_SIZE-1:0]   watchdogCnt,
  output logic [LOG_QUEUE_SIZE:0]    outstanding,
  output logic [ERR_BITS-1:0]        errorCode
);

  throttle_state_e state_q, state_d;

  logic [GAP_WIDTH-1:0]       gap_q, gap_d;
  logic [ADDR_BITS-1:0]       addr_q;
  logic [BURST_LEN_WIDTH-1:0] len_q;
  logic [TID_WIDTH-1:0]       id_q;
  logic [LOG_QUEUE_SIZE:0]    out_q, out_d;
  logic [ERR_BITS-1:0]        err_q, err_d;

  logic s_hs, m_hs, r_beat, retire, wd_timeout;

  assign s_hs   = s_ar_valid & s_ar_ready;
  assign m_hs   = m_ar_valid & m_ar_ready;
  assign r_beat = r_valid & r_ready;
  assign retire = r_beat & r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (s_hs) state_d = HOLD;
      HOLD:    if (m_ar_ready) state_d = (crs_minGap != '0) ? GAP : EMPTY;
      GAP:     if (gap_d == '0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Ready depends on registered state only, so no path from m_ar_ready reaches s_ar_ready.
  always_comb begin
    m_ar_valid = (state_q == HOLD);
    s_ar_ready = en && (state_q == EMPTY) && (out_q < crs_maxOutstanding);
  end

  always_comb begin
    gap_d = gap_q;
    if (m_hs) begin
      gap_d = crs_minGap;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (m_hs && !retire) begin
      out_d = out_q + 1'b1;
    end else if (retire && !m_hs) begin
      if (out_q == '0) begin
        err_d[ERR_UNDERFLOW] = 1'b1;
      end else begin
        out_d = out_q - 1'b1;
      end
    end
    if (wd_timeout) begin
      err_d[ERR_WATCHDOG] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q  <= '0;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      out_q  <= '0;
      err_q  <= '0;
    end else begin
      gap_q <= gap_d;
      out_q <= out_d;
      err_q <= err_d;
      if (s_hs) begin
        addr_q <= s_ar_addr;
        len_q  <= s_ar_len;
        id_q   <= s_ar_id;
      end
    end
  end

  prefetch_watchdog #(
    .WIDTH(WATCHDOG_SIZE)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear_i    ((out_q == '0) || r_beat),
    .threshold_i(watchdogCnt),
    .timeout_o  (wd_timeout)
  );

  assign m_ar_addr   = addr_q;
  assign m_ar_len    = len_q;
  assign m_ar_id     = id_q;
  assign outstanding = out_q;
  assign errorCode   = err_q;

endmodule

// File: tb/tb_prefetch_ar_throttle.sv
// Bench for prefetch_ar_throttle: directed scenarios plus randomized traffic against a scoreboard model.
module tb_prefetch_ar_throttle;
  import prefetch_pkg::*;

  localparam int AW = 16;
  localparam int LW = 8;
  localparam int IW = 8;
  localparam int LQ = 3;
  localparam int GW = 6;
  localparam int WW = 10;
  localparam int OW = LQ + 1;
  localparam int PW = AW + LW + IW;

  logic          clk = 1'b0;
  logic          rst, en;
  logic          s_ar_valid, s_ar_ready;
  logic [AW-1:0] s_ar_addr;
  logic [LW-1:0] s_ar_len;
  logic [IW-1:0] s_ar_id;
  logic          m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic [LW-1:0] m_ar_len;
  logic [IW-1:0] m_ar_id;
  logic          r_valid, r_ready, r_last;
  logic [OW-1:0] crs_maxOutstanding;
  logic [GW-1:0] crs_minGap;
  logic [WW-1:0] watchdogCnt;
  logic [OW-1:0] outstanding;
  logic [1:0]    errorCode;

  always #5 clk = ~clk;

  prefetch_ar_throttle #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
    .LOG_QUEUE_SIZE(LQ), .GAP_WIDTH(GW), .WATCHDOG_SIZE(WW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .crs_maxOutstanding(crs_maxOutstanding), .crs_minGap(crs_minGap),
    .watchdogCnt(watchdogCnt), .outstanding(outstanding), .errorCode(errorCode)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard model: accepted requests in order, burst count, underflow flag, issue cycles.
  int            cyc = 0;
  int            exp_out = 0;
  logic          exp_underflow = 1'b0;
  int            m_hs_cnt = 0;
  int            m_hs_cyc[$];
  logic [PW-1:0] req_q[$];
  int            payload_bad = 0;
  int            hold_bad = 0;
  int            ready_bad = 0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_payload = '0;

  always @(posedge clk) begin : monitor
    logic [PW-1:0] mp;
    logic [PW-1:0] ep;
    cyc++;
    if (!rst) begin
      mp = {m_ar_addr, m_ar_len, m_ar_id};
      if (prev_stall && (!m_ar_valid || mp != prev_payload)) hold_bad++;
      prev_stall   = m_ar_valid && !m_ar_ready;
      prev_payload = mp;
      if (s_ar_ready && (!en || exp_out >= int'(crs_maxOutstanding))) ready_bad++;
      if (s_ar_valid && s_ar_ready) req_q.push_back({s_ar_addr, s_ar_len, s_ar_id});
      if (m_ar_valid && m_ar_ready) begin
        m_hs_cnt++;
        m_hs_cyc.push_back(cyc);
        if (req_q.size() == 0) payload_bad++;
        else begin
          ep = req_q.pop_front();
          if (ep != mp) payload_bad++;
        end
        if (!(r_valid && r_ready && r_last)) exp_out++;
      end else if (r_valid && r_ready && r_last) begin
        if (exp_out == 0) exp_underflow = 1'b1;
        else exp_out--;
      end
    end
  end

  task automatic clear_model();
    exp_out = 0;
    exp_underflow = 1'b0;
    req_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    s_ar_valid = 1'b0;
    m_ar_ready = 1'b1;
    tick(8);
    n = exp_out;
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    tick(n);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
    m_ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    crs_maxOutstanding = OW'(DEF_MAX_OUTSTANDING);
    crs_minGap = GW'(DEF_MIN_GAP);
    watchdogCnt = WW'(DEF_WATCHDOG_CNT);
    tick(3);
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_m_ar_valid got %0b want 0", m_ar_valid); end
    checks++; if ({m_ar_addr, m_ar_len, m_ar_id} !== {PW{1'b0}}) begin errors++; $display("FAIL reset_payload got %h want 0", {m_ar_addr, m_ar_len, m_ar_id}); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (errorCode !== 2'b00) begin errors++; $display("FAIL reset_errorCode got %b want 00", errorCode); end
    rst = 1'b0;
    clear_model();
    tick(1);
    checks++; if (s_ar_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ar_ready got %0b want 1", s_ar_ready); end
  endtask

  task automatic test_cap();
    int base;
    crs_maxOutstanding = 4'd2; crs_minGap = '0; m_ar_ready = 1'b1;
    base = m_hs_cnt;
    s_ar_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_ar_addr = AW'($urandom); s_ar_len = LW'($urandom); s_ar_id = IW'($urandom);
      tick(1);
    end
    checks++; if (m_hs_cnt - base != 2) begin errors++; $display("FAIL cap_issue_count got %0d want 2", m_hs_cnt - base); end
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL cap_outstanding got %0d want 2", outstanding); end
    checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL cap_s_ar_ready got %0b want 0", s_ar_ready); end
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    tick(1);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    tick(6);
    checks++; if (m_hs_cnt - base != 3) begin errors++; $display("FAIL cap_third_issue got %0d want 3", m_hs_cnt - base); end
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL cap_outstanding_after got %0d want 2", outstanding); end
    checks++; if (s_ar_ready !== 1'b0) begin errors++; $display("FAIL cap_s_ar_ready_after got %0b want 0", s_ar_ready); end
    drain();
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL cap_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_gap();
    int start;
    int n;
    crs_maxOutstanding = 4'd15; crs_minGap = 6'd5; m_ar_ready = 1'b1;
    start = m_hs_cyc.size();
    s_ar_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_ar_addr = AW'($urandom); s_ar_len = LW'($urandom); s_ar_id = IW'($urandom);
      tick(1);
    end
    s_ar_valid = 1'b0;
    n = m_hs_cyc.size() - start;
    checks++; if (n != 4) begin errors++; $display("FAIL gap_issue_count got %0d want 4", n); end
    for (int i = start + 1; i < m_hs_cyc.size(); i++) begin
      checks++;
      if (m_hs_cyc[i] - m_hs_cyc[i-1] != 7) begin
        errors++; $display("FAIL gap_spacing got %0d want 7", m_hs_cyc[i] - m_hs_cyc[i-1]);
      end
    end
    drain();
    crs_minGap = '0;
  endtask

  task automatic test_backpressure();
    int base;
    logic [PW-1:0] want;
    crs_maxOutstanding = 4'd4; crs_minGap = '0; m_ar_ready = 1'b0;
    base = m_hs_cnt;
    s_ar_addr = 16'h0eef; s_ar_len = 8'd3; s_ar_id = 8'd5;
    want = {s_ar_addr, s_ar_len, s_ar_id};
    s_ar_valid = 1'b1;
    tick(1);
    s_ar_valid = 1'b0;
    s_ar_addr = 16'hffff; s_ar_len = 8'hff; s_ar_id = 8'hff;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({m_ar_valid, m_ar_addr, m_ar_len, m_ar_id} !== {1'b1, want}) begin
        errors++; $display("FAIL bp_hold cycle %0d got %0b/%h want 1/%h", i, m_ar_valid, {m_ar_addr, m_ar_len, m_ar_id}, want);
      end
      tick(1);
    end
    m_ar_ready = 1'b1;
    tick(1);
    checks++; if (m_hs_cnt - base != 1) begin errors++; $display("FAIL bp_issue_count got %0d want 1", m_hs_cnt - base); end
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %0b want 0", m_ar_valid); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL bp_outstanding got %0d want 1", outstanding); end
  endtask

  task automatic test_simultaneous();
    int base;
    m_ar_ready = 1'b0;
    base = m_hs_cnt;
    s_ar_addr = 16'h1234; s_ar_len = 8'd1; s_ar_id = 8'd9;
    s_ar_valid = 1'b1;
    tick(1);
    s_ar_valid = 1'b0;
    tick(1);
    m_ar_ready = 1'b1; r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    tick(1);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    checks++; if (m_hs_cnt - base != 1) begin errors++; $display("FAIL sim_issue_count got %0d want 1", m_hs_cnt - base); end
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL sim_outstanding got %0d want 1", outstanding); end
    checks++; if (errorCode !== 2'b00) begin errors++; $display("FAIL sim_errorCode got %b want 00", errorCode); end
    drain();
  endtask

  task automatic test_watchdog();
    crs_maxOutstanding = 4'd4; crs_minGap = '0; m_ar_ready = 1'b1;
    watchdogCnt = 10'd10;
    s_ar_addr = 16'h0100; s_ar_len = 8'd7; s_ar_id = 8'd2;
    s_ar_valid = 1'b1;
    tick(1);
    s_ar_valid = 1'b0;
    tick(1);
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL wd_issued got %0d want 1", outstanding); end
    tick(9);
    checks++; if (errorCode !== 2'b00) begin errors++; $display("FAIL wd_early got %b want 00", errorCode); end
    tick(1);
    checks++; if (errorCode !== 2'b10) begin errors++; $display("FAIL wd_timeout got %b want 10", errorCode); end
    drain();
    checks++; if (errorCode !== 2'b10) begin errors++; $display("FAIL wd_sticky got %b want 10", errorCode); end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    clear_model();
    watchdogCnt = '0;
    tick(1);
    checks++; if (errorCode !== 2'b00) begin errors++; $display("FAIL wd_rst_clear got %b want 00", errorCode); end
  endtask

  task automatic test_underflow_reset();
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1;
    tick(1);
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    checks++; if (errorCode !== {1'b0, exp_underflow} || exp_underflow !== 1'b1) begin errors++; $display("FAIL uf_errorCode got %b want 01", errorCode); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL uf_outstanding got %0d want 0", outstanding); end
    m_ar_ready = 1'b0;
    s_ar_addr = 16'habcd; s_ar_len = 8'd4; s_ar_id = 8'd3;
    s_ar_valid = 1'b1;
    tick(1);
    s_ar_valid = 1'b0;
    checks++; if (m_ar_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_setup got %0b want 1", m_ar_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b want 0", m_ar_valid); end
    checks++; if ({m_ar_addr, m_ar_len, m_ar_id} !== {PW{1'b0}}) begin errors++; $display("FAIL rst_async_payload got %h want 0", {m_ar_addr, m_ar_len, m_ar_id}); end
    checks++; if ({outstanding, errorCode} !== '0) begin errors++; $display("FAIL rst_async_counters got %0d/%b want 0/00", outstanding, errorCode); end
    tick(1);
    rst = 1'b0;
    clear_model();
    m_ar_ready = 1'b1;
    tick(2);
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL rst_dropped_request got %0b want 0", m_ar_valid); end
  endtask

  task automatic test_random();
    int start;
    int gap;
    int spacing_bad;
    for (int round = 0; round < 3; round++) begin
      crs_maxOutstanding = OW'($urandom_range(1, 15));
      gap = $urandom_range(0, 3);
      crs_minGap = GW'(gap);
      start = m_hs_cyc.size();
      for (int i = 0; i < 500; i++) begin
        en = ($urandom_range(0, 7) != 0);
        s_ar_valid = 1'($urandom_range(0, 1));
        s_ar_addr = AW'($urandom); s_ar_len = LW'($urandom); s_ar_id = IW'($urandom);
        m_ar_ready = ($urandom_range(0, 3) != 0);
        r_valid = 1'($urandom_range(0, 1));
        r_ready = 1'($urandom_range(0, 1));
        r_last = ($urandom_range(0, 2) == 0);
        tick(1);
        checks++;
        if (outstanding !== OW'(exp_out)) begin
          errors++; $display("FAIL rnd_outstanding round %0d cycle %0d got %0d want %0d", round, i, outstanding, exp_out);
        end
      end
      spacing_bad = 0;
      for (int k = start + 1; k < m_hs_cyc.size(); k++)
        if (m_hs_cyc[k] - m_hs_cyc[k-1] < 2 + gap) spacing_bad++;
      checks++; if (spacing_bad != 0) begin errors++; $display("FAIL rnd_min_spacing round %0d violations %0d want 0", round, spacing_bad); end
      checks++; if (errorCode !== {1'b0, exp_underflow}) begin errors++; $display("FAIL rnd_errorCode round %0d got %b want 0%b", round, errorCode, exp_underflow); end
    end
    en = 1'b1;
    drain();
    checks++; if (outstanding !== OW'(exp_out)) begin errors++; $display("FAIL rnd_drained got %0d want %0d", outstanding, exp_out); end
  endtask

  task automatic test_scoreboard();
    checks++; if (payload_bad != 0) begin errors++; $display("FAIL sb_payload_order mismatches %0d want 0", payload_bad); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL sb_hold_stable violations %0d want 0", hold_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL sb_ready_gating violations %0d want 0", ready_bad); end
  endtask

  initial begin
    test_reset();
    test_cap();
    test_gap();
    test_backpressure();
    test_simultaneous();
    test_watchdog();
    test_underflow_reset();
    test_random();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
